rc_osc_clkgen: RTL
==================

# rc_osc_clkgen

Parametrised clock generator that sits directly behind the RC oscillator and runs on its output clock. It gates the oscillator clock through a startup settling window and then produces NCH independently divided, glitch-free output clocks. Divide ratio and enable are programmable per channel. Shutdown drains every channel to a clean low level. It replaces ad-hoc use of the raw oscillator clock in the brownout IP and in downstream timers.

## Interface
- NCH, 2: number of divided output channels (1..8).
- DIVW, 8: width of each channel's divide setting.
- SETTLE, 16: oscillator settling cycles before outputs run (2..2^12-1).
- osc_ck  in  1  oscillator clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  generator enable, synchronous to osc_ck.
- ch_en  in  NCH  per-channel enable request.
- ch_div  in  NCH*DIVW  per-channel divide setting; channel i uses bits [i*DIVW +: DIVW].
- ready  out  1  high while in RUN.
- ck_out  out  NCH  divided clocks, registered.
- busy  out  1  high in SETTLE or DRAIN.

## Operation
- States: OFF, SETTLE, RUN, DRAIN.
  - OFF: ena=1 → SETTLE; settle counter cleared.
  - SETTLE: counter increments each cycle. At count SETTLE-1 → RUN. ena=0 → OFF immediately.
  - RUN: ena=0 → DRAIN.
  - DRAIN: → OFF once all ck_out are low and every channel is at a period boundary. ena=1 → RUN; channels keep running.
- Each channel has a counter cnt (DIVW bits), an output bit, and shadow registers div_s and en_s.
- Shadow load: div_s and en_s load from ch_div/ch_en only at a period boundary. A boundary is either the channel being idle, or cnt==div_s while the output is high (output about to fall).
- Running channel: cnt counts 0..div_s. When cnt==div_s, the output toggles and cnt returns to 0.
- Output period is 2*(div_s+1) osc_ck cycles at 50% duty. div=0 gives divide-by-2. div=2^DIVW-1 gives the maximum.
- A channel runs only when en_s=1 and state is RUN or DRAIN. Otherwise the output is low and cnt=0.
- Disable mid-period: a high phase always completes. The output falls on its normal schedule, then the channel idles. The output never produces a runt pulse.
- Divide change mid-period: the current period completes with the old div_s. The new value applies from the next low phase.
- DRAIN: channels stop loading en_s=1. Each channel finishes its current period and then idles.
- Reset mid-operation: all state clears asynchronously and outputs go low at once; rst is the only non-glitch-free path.

## Timing
- Reset values: ready=0, busy=0, ck_out=0, state OFF, all counters and shadows 0.
- ena sampled high at edge k: busy=1 after edge k; ready=1 and busy=0 after edge k+SETTLE.
- RUN entry at edge r: each enabled channel loads its shadows at edge r. Its first rising ck_out is at edge r+div+1.
- ena sampled low in RUN at edge d: ready=0 and busy=1 after edge d. DRAIN→OFF at the edge after the last channel idles.
- Shadow load has a 1-cycle latency from the boundary edge. ch_en/ch_div changes outside a boundary have no effect until the next boundary.
- No combinational path from inputs to outputs.

## Structure
- Package rc_osc_pkg: state enum (OFF, SETTLE, RUN, DRAIN) and the settle-counter width constant (12).
- Sub-module rc_osc_div_ch: one channel, containing counter, output flop and shadows. It is instantiated NCH times in a generate loop. The top holds the FSM and settle counter.

## Test plan
- Reset: assert rst mid-RUN with ch0 high → ck_out=0, ready=0 asynchronously; after release, state is OFF.
- Settle: SETTLE=16, ena rises at edge 0 → ready=1 after edge 16. Drop ena at edge 8 → OFF, ready never rises.
- Divide: ch0 div=0 and ch1 div=3 → periods of 2 and 8 cycles, 50% duty, first rises at r+1 and r+4.
- Reprogram: ch1 div changes 3→1 mid high phase → the current period stays 8 cycles and the next period is 4 cycles.
- Disable: ch_en[0]=0 one cycle after ch0 rises (div=3) → high lasts the full 4 cycles, then ck_out[0] stays low.
- Drain: ena=0 in RUN with ch1 mid-high → ready=0 next cycle, ch1 completes its high phase, then OFF with busy=0. Re-asserting ena during DRAIN → RUN with no SETTLE.

Source files
------------

// File: rtl/rc_osc_pkg.sv
// Shared types and constants for the RC oscillator clock generator.
package rc_osc_pkg;

    localparam int SETTLE_CW = 12;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SETTLE,
        ST_RUN,
        ST_DRAIN
    } osc_state_t;

    // Channels may only count while the generator is running or draining.
    function automatic logic state_active(input osc_state_t s);
        return (s == ST_RUN) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/rc_osc_div_ch.sv
// One divided output channel: period counter, output flop and the
// shadowed enable/divide that only change at a period boundary.
module rc_osc_div_ch #(
    parameter int DIVW = 8
) (
    input  logic            osc_ck,
    input  logic            rst,
    input  logic            active,
    input  logic            draining,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            ck,
    output logic            idle
);

    logic [DIVW-1:0] cnt;
    logic [DIVW-1:0] div_s;
    logic            en_s;
    logic            running;

    assign running = en_s & active;
    assign idle    = ~running;

    // A boundary is either idling or the last cycle of the high phase.
    // Shadows load only there, so a period is never cut short. While
    // draining, no channel is allowed to pick up a fresh enable.
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            ck    <= 1'b0;
            div_s <= '0;
            en_s  <= 1'b0;
        end else if (!running) begin
            cnt   <= '0;
            ck    <= 1'b0;
            div_s <= div;
            en_s  <= en & ~draining;
        end else if (cnt == div_s) begin
            cnt <= '0;
            ck  <= ~ck;
            if (ck) begin
                div_s <= div;
                en_s  <= en & ~draining;
            end
        end else begin
            cnt <= cnt + DIVW'(1);
        end
    end

endmodule

// File: rtl/rc_osc_clkgen.sv
// Clock generator behind the RC oscillator: settle window, then NCH
// glitch-free divided clocks, with a draining shutdown.
module rc_osc_clkgen
    import rc_osc_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int DIVW   = 8,
    parameter int SETTLE = 16
) (
    input  logic                osc_ck,
    input  logic                rst,
    input  logic                ena,
    input  logic [NCH-1:0]      ch_en,
    input  logic [NCH*DIVW-1:0] ch_div,
    output logic                ready,
    output logic [NCH-1:0]      ck_out,
    output logic                busy
);

    localparam logic [SETTLE_CW-1:0] SETTLE_LAST = SETTLE_CW'(SETTLE - 1);

    osc_state_t           state;
    logic [SETTLE_CW-1:0] settle_cnt;
    logic [NCH-1:0]       ch_idle;
    logic                 all_idle;
    logic                 active;
    logic                 draining;

    assign all_idle = &ch_idle;
    assign active   = state_active(state);
    assign draining = (state == ST_DRAIN);

    // ready/busy are registered alongside the state so no input ever
    // reaches an output combinationally. Re-enabling during DRAIN returns
    // straight to RUN because the oscillator is already known to be stable.
    always_ff @(posedge osc_ck or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            settle_cnt <= '0;
            ready      <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_OFF: begin
                    if (ena) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!ena) begin
                        state <= ST_OFF;
                        busy  <= 1'b0;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_CW'(1);
                    end
                end
                ST_RUN: begin
                    if (!ena) begin
                        state <= ST_DRAIN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (ena) begin
                        state <= ST_RUN;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else if (all_idle) begin
                        state <= ST_OFF;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    ready <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        rc_osc_div_ch #(
            .DIVW(DIVW)
        ) u_ch (
            .osc_ck   (osc_ck),
            .rst      (rst),
            .active   (active),
            .draining (draining),
            .en       (ch_en[i]),
            .div      (ch_div[i*DIVW +: DIVW]),
            .ck       (ck_out[i]),
            .idle     (ch_idle[i])
        );
    end

endmodule
